// File: rtl/stopwatch_bcd_counter.sv
// stopwatch_bcd_counter: M:SS.t stopwatch with four BCD digits and IDLE/RUN/PAUSE control.
// A prescaler divides clk down to TICK_HZ; each tick advances the tenths digit and
// ripples carries up to the minutes digit, which wraps 9:59.9 -> 0:00.0.
// Optional feature: define STOPWATCH_LAP_EN to add the lap input and a lap-hold
// display freeze; without it the display always shows the live count.
`timescale 1ns/1ps
module stopwatch_bcd_counter #(
    parameter int unsigned CLK_HZ  = 50000000,
    parameter int unsigned TICK_HZ = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_stop,
    input  logic       clear,
`ifdef STOPWATCH_LAP_EN
    input  logic       lap,
`endif
    output logic [3:0] bcd0,
    output logic [3:0] bcd1,
    output logic [3:0] bcd2,
    output logic [3:0] bcd3,
    output logic       running,
    output logic       wrap
);
    localparam int unsigned DIV = ((CLK_HZ / TICK_HZ) > 0) ? (CLK_HZ / TICK_HZ) : 1;
    localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
    localparam logic [PW-1:0] PRE_ZERO = {PW{1'b0}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    d0_q, d0_d, d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
    logic          running_q, running_d;
    logic          wrap_q, wrap_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [15:0]   disp_q, disp_d;
    logic          tick_s, c1_s, c2_s, c3_s;

    // Advance one BCD digit, returning to zero at its last legal value.
    // Using >= keeps the digit in range even if it were ever corrupted.
    function automatic logic [3:0] digit_inc(input logic [3:0] d, input logic [3:0] last);
        logic [3:0] r;
        if (d >= last) begin
            r = 4'd0;
        end else begin
            r = d + 4'd1;
        end
        return r;
    endfunction

    assign tick_s = (state_q == RUN) && (presc_q == PRE_LAST);
    assign c1_s   = tick_s && (d0_q == 4'd9);
    assign c2_s   = c1_s && (d1_q == 4'd9);
    assign c3_s   = c2_s && (d2_q == 4'd5);
    assign cnt_q  = {d3_q, d2_q, d1_q, d0_q};
    assign cnt_d  = {d3_d, d2_d, d1_d, d0_d};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: clear wins, otherwise start_stop toggles run/pause.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else if (start_stop) begin
            case (state_q)
                IDLE:    state_d = RUN;
                RUN:     state_d = PAUSE;
                PAUSE:   state_d = RUN;
                default: state_d = IDLE;
            endcase
        end else begin
            case (state_q)
                IDLE, RUN, PAUSE: state_d = state_q;
                default:          state_d = IDLE;
            endcase
        end
    end

    // FSM output decode: running follows the state being entered.
    always_comb begin
        case (state_d)
            RUN:     running_d = 1'b1;
            IDLE:    running_d = 1'b0;
            PAUSE:   running_d = 1'b0;
            default: running_d = 1'b0;
        endcase
    end

    // Prescaler and digit chain next-state; a tick coincident with start_stop still completes.
    always_comb begin
        presc_d = presc_q;
        d0_d    = d0_q;
        d1_d    = d1_q;
        d2_d    = d2_q;
        d3_d    = d3_q;
        wrap_d  = 1'b0;
        if (clear) begin
            presc_d = PRE_ZERO;
            d0_d    = 4'd0;
            d1_d    = 4'd0;
            d2_d    = 4'd0;
            d3_d    = 4'd0;
        end else begin
            case (state_q)
                RUN: begin
                    if (tick_s) begin
                        presc_d = PRE_ZERO;
                        d0_d    = digit_inc(d0_q, 4'd9);
                    end else begin
                        presc_d = presc_q + PW'(1'b1);
                        d0_d    = d0_q;
                    end
                    if (c1_s) begin
                        d1_d = digit_inc(d1_q, 4'd9);
                    end else begin
                        d1_d = d1_q;
                    end
                    if (c2_s) begin
                        d2_d = digit_inc(d2_q, 4'd5);
                    end else begin
                        d2_d = d2_q;
                    end
                    if (c3_s) begin
                        d3_d = digit_inc(d3_q, 4'd9);
                    end else begin
                        d3_d = d3_q;
                    end
                    wrap_d = c3_s && (d3_q == 4'd9);
                end
                PAUSE: presc_d = presc_q;
                IDLE:  presc_d = PRE_ZERO;
                default: begin
                    presc_d = PRE_ZERO;
                    d0_d    = 4'd0;
                    d1_d    = 4'd0;
                    d2_d    = 4'd0;
                    d3_d    = 4'd0;
                end
            endcase
        end
    end

    // Count registers: prescaler and live digits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= PRE_ZERO;
            d0_q    <= 4'd0;
            d1_q    <= 4'd0;
            d2_q    <= 4'd0;
            d3_q    <= 4'd0;
        end else begin
            presc_q <= presc_d;
            d0_q    <= d0_d;
            d1_q    <= d1_d;
            d2_q    <= d2_d;
            d3_q    <= d3_d;
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic        hold_q, hold_d;
    logic [15:0] snap_q, snap_d;

    // Lap hold: toggled by lap outside IDLE, snapshot captured as hold engages, released by clear.
    always_comb begin
        hold_d = hold_q;
        snap_d = snap_q;
        if (clear) begin
            hold_d = 1'b0;
        end else if (lap && (state_q != IDLE)) begin
            hold_d = ~hold_q;
            if (!hold_q) begin
                snap_d = cnt_q;
            end else begin
                snap_d = snap_q;
            end
        end else begin
            hold_d = hold_q;
        end
        if (hold_d) begin
            disp_d = snap_d;
        end else begin
            disp_d = cnt_d;
        end
    end

    // Lap hold registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= 1'b0;
            snap_q <= 16'h0000;
        end else begin
            hold_q <= hold_d;
            snap_q <= snap_d;
        end
    end
`else
    // Display always mirrors the live count.
    always_comb begin
        disp_d = cnt_d;
    end
`endif

    // Output registers, loaded from next-state values so digits change right after the tick edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_q    <= 16'h0000;
            running_q <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            disp_q    <= disp_d;
            running_q <= running_d;
            wrap_q    <= wrap_d;
        end
    end

    assign bcd0    = disp_q[3:0];
    assign bcd1    = disp_q[7:4];
    assign bcd2    = disp_q[11:8];
    assign bcd3    = disp_q[15:12];
    assign running = running_q;
    assign wrap    = wrap_q;

endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// Testbench for stopwatch_bcd_counter with CLK_HZ=10, TICK_HZ=1 (divisor 10).
// Directed vector table plus hand-written sequences for async reset and 9:59.9 wrap.
`timescale 1ns/1ps
module tb_stopwatch_bcd_counter;
    logic       clk;
    logic       clk_en;
    logic       rst_n;
    logic       start_stop;
    logic       clear;
`ifdef STOPWATCH_LAP_EN
    logic       lap_s;
`endif
    logic [3:0] bcd0, bcd1, bcd2, bcd3;
    logic       running;
    logic       wrap;
    logic [15:0] dig;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       name;
        logic        ss;
        logic        clr;
        logic        lp;
        int unsigned ncyc;
        logic [15:0] exp_bcd;
        logic        exp_run;
        logic        exp_wrap;
    } vec_t;

    vec_t vecs[$];

    stopwatch_bcd_counter #(.CLK_HZ(10), .TICK_HZ(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_stop (start_stop),
        .clear      (clear),
`ifdef STOPWATCH_LAP_EN
        .lap        (lap_s),
`endif
        .bcd0       (bcd0),
        .bcd1       (bcd1),
        .bcd2       (bcd2),
        .bcd3       (bcd3),
        .running    (running),
        .wrap       (wrap)
    );

    assign dig = {bcd3, bcd2, bcd1, bcd0};

    // Gateable clock so reset can be exercised with no edges.
    always #5 if (clk_en) clk = ~clk;

    function automatic vec_t mk(input string nm, input logic ss, input logic clr, input logic lp,
                                input int unsigned n, input logic [15:0] eb, input logic er,
                                input logic ew);
        vec_t v;
        v.name = nm; v.ss = ss; v.clr = clr; v.lp = lp; v.ncyc = n;
        v.exp_bcd = eb; v.exp_run = er; v.exp_wrap = ew;
        return v;
    endfunction

    // Expected M:SS.t digits for a given number of ticks since zero.
    function automatic logic [15:0] model_digits(input int unsigned t);
        int unsigned m;
        m = t % 6000;
        return {4'(m / 600), 4'((m / 100) % 6), 4'((m / 10) % 10), 4'(m % 10)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_out(input string nm, input logic [15:0] eb, input logic er, input logic ew);
        chk({nm, ".digits"}, {16'h0000, dig}, {16'h0000, eb});
        chk({nm, ".running"}, {31'd0, running}, {31'd0, er});
        chk({nm, ".wrap"}, {31'd0, wrap}, {31'd0, ew});
    endtask

    // Pulse inputs for the first cycle, idle for the rest, then check after the last edge.
    task automatic apply(input vec_t v);
        start_stop = v.ss;
        clear      = v.clr;
`ifdef STOPWATCH_LAP_EN
        lap_s      = v.lp;
`endif
        @(negedge clk);
        start_stop = 1'b0;
        clear      = 1'b0;
`ifdef STOPWATCH_LAP_EN
        lap_s      = 1'b0;
`endif
        for (int i = 1; i < int'(v.ncyc); i++) @(negedge clk);
        check_out(v.name, v.exp_bcd, v.exp_run, v.exp_wrap);
    endtask

    // Watchdog: the bench never waits on DUT events, but bound the run anyway.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clk = 1'b0; clk_en = 1'b1; rst_n = 1'b0;
        start_stop = 1'b0; clear = 1'b0;
`ifdef STOPWATCH_LAP_EN
        lap_s = 1'b0;
`endif
        //            name             ss    clr   lap   n     digits    run   wrap
        vecs.push_back(mk("idle",          1'b0, 1'b0, 1'b0, 1,    16'h0000, 1'b0, 1'b0));
        vecs.push_back(mk("start_pre",     1'b1, 1'b0, 1'b0, 10,   16'h0000, 1'b1, 1'b0));
        vecs.push_back(mk("first_tick",    1'b0, 1'b0, 1'b0, 1,    16'h0001, 1'b1, 1'b0));
        vecs.push_back(mk("run_30",        1'b0, 1'b0, 1'b0, 20,   16'h0003, 1'b1, 1'b0));
        vecs.push_back(mk("pause",         1'b1, 1'b0, 1'b0, 1,    16'h0003, 1'b0, 1'b0));
        vecs.push_back(mk("pause_hold",    1'b0, 1'b0, 1'b0, 50,   16'h0003, 1'b0, 1'b0));
        vecs.push_back(mk("resume",        1'b1, 1'b0, 1'b0, 1,    16'h0003, 1'b1, 1'b0));
        vecs.push_back(mk("resume_pre",    1'b0, 1'b0, 1'b0, 8,    16'h0003, 1'b1, 1'b0));
        vecs.push_back(mk("resume_tick",   1'b0, 1'b0, 1'b0, 1,    16'h0004, 1'b1, 1'b0));
        vecs.push_back(mk("clear_run",     1'b0, 1'b1, 1'b0, 1,    16'h0000, 1'b0, 1'b0));
        vecs.push_back(mk("clr_ss_idle",   1'b1, 1'b1, 1'b0, 1,    16'h0000, 1'b0, 1'b0));
        vecs.push_back(mk("idle_stays",    1'b0, 1'b0, 1'b0, 20,   16'h0000, 1'b0, 1'b0));
        vecs.push_back(mk("p_run15",       1'b1, 1'b0, 1'b0, 15,   16'h0001, 1'b1, 1'b0));
        vecs.push_back(mk("p_pause",       1'b1, 1'b0, 1'b0, 1,    16'h0001, 1'b0, 1'b0));
        vecs.push_back(mk("p_hold50",      1'b0, 1'b0, 1'b0, 50,   16'h0001, 1'b0, 1'b0));
        vecs.push_back(mk("p_resume",      1'b1, 1'b0, 1'b0, 1,    16'h0001, 1'b1, 1'b0));
        vecs.push_back(mk("p_pre4",        1'b0, 1'b0, 1'b0, 4,    16'h0001, 1'b1, 1'b0));
        vecs.push_back(mk("p_tick5",       1'b0, 1'b0, 1'b0, 1,    16'h0002, 1'b1, 1'b0));
        vecs.push_back(mk("p_clear",       1'b0, 1'b1, 1'b0, 1,    16'h0000, 1'b0, 1'b0));
        vecs.push_back(mk("coinc_pre",     1'b1, 1'b0, 1'b0, 10,   16'h0000, 1'b1, 1'b0));
        vecs.push_back(mk("coinc_tick_ss", 1'b1, 1'b0, 1'b0, 1,    16'h0001, 1'b0, 1'b0));
        vecs.push_back(mk("coinc_frozen",  1'b0, 1'b0, 1'b0, 30,   16'h0001, 1'b0, 1'b0));
        vecs.push_back(mk("coinc_clear",   1'b0, 1'b1, 1'b0, 1,    16'h0000, 1'b0, 1'b0));
        vecs.push_back(mk("run_12_4",      1'b1, 1'b0, 1'b0, 1241, 16'h0124, 1'b1, 1'b0));
        vecs.push_back(mk("clr_ss_run",    1'b1, 1'b1, 1'b0, 1,    16'h0000, 1'b0, 1'b0));
        vecs.push_back(mk("after_clr",     1'b0, 1'b0, 1'b0, 5,    16'h0000, 1'b0, 1'b0));
`ifdef STOPWATCH_LAP_EN
        vecs.push_back(mk("lap_run",       1'b1, 1'b0, 1'b0, 21,   16'h0002, 1'b1, 1'b0));
        vecs.push_back(mk("lap_set",       1'b0, 1'b0, 1'b1, 1,    16'h0002, 1'b1, 1'b0));
        vecs.push_back(mk("lap_held",      1'b0, 1'b0, 1'b0, 39,   16'h0002, 1'b1, 1'b0));
        vecs.push_back(mk("lap_release",   1'b0, 1'b0, 1'b1, 1,    16'h0006, 1'b1, 1'b0));
        vecs.push_back(mk("lap_pause",     1'b1, 1'b0, 1'b0, 1,    16'h0006, 1'b0, 1'b0));
        vecs.push_back(mk("lap_set_pause", 1'b0, 1'b0, 1'b1, 1,    16'h0006, 1'b0, 1'b0));
        vecs.push_back(mk("lap_resume",    1'b1, 1'b0, 1'b0, 1,    16'h0006, 1'b1, 1'b0));
        vecs.push_back(mk("lap_held_run",  1'b0, 1'b0, 1'b0, 8,    16'h0006, 1'b1, 1'b0));
        vecs.push_back(mk("lap_clr",       1'b0, 1'b1, 1'b0, 1,    16'h0000, 1'b0, 1'b0));
        vecs.push_back(mk("lap_idle",      1'b0, 1'b0, 1'b1, 1,    16'h0000, 1'b0, 1'b0));
        vecs.push_back(mk("lap_idle_run",  1'b1, 1'b0, 1'b0, 11,   16'h0001, 1'b1, 1'b0));
        vecs.push_back(mk("lap_clr2",      1'b0, 1'b1, 1'b0, 1,    16'h0000, 1'b0, 1'b0));
`endif

        // Reset state, before any clock edge.
        #2;
        check_out("reset", 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) apply(vecs[i]);

        // Async reset mid-count at 0:00.7 with the clock stopped.
        apply(mk("pre_rst_run", 1'b1, 1'b0, 1'b0, 71, 16'h0007, 1'b1, 1'b0));
        clk_en = 1'b0;
        #1;
        rst_n = 1'b0;
        #3;
        check_out("async_rst", 16'h0000, 1'b0, 1'b0);
        rst_n = 1'b1;
        #3;
        check_out("rst_release_noclk", 16'h0000, 1'b0, 1'b0);
        clk_en = 1'b1;
        @(negedge clk);
        check_out("post_rst_idle", 16'h0000, 1'b0, 1'b0);

        // Count from 0:00.0 through 9:59.9 and wrap, against the tick model.
        start_stop = 1'b1;
        for (int k = 0; k <= 60001; k++) begin
            @(negedge clk);
            start_stop = 1'b0;
            if ((k % 10 == 0) || (k % 10 == 9)) begin
                chk("wrap_seq.digits", {16'h0000, dig}, {16'h0000, model_digits(k / 10)});
            end
            chk("wrap_seq.wrap", {31'd0, wrap}, {31'd0, (k == 60000)});
            if (k == 59999) begin
                chk("wrap_seq.max", {16'h0000, dig}, {16'h0000, 16'h9599});
            end
            if (k == 60000) begin
                chk("wrap_seq.zero", {16'h0000, dig}, 32'h0000_0000);
                chk("wrap_seq.running", {31'd0, running}, 32'd1);
            end
        end
        chk("wrap_seq.still_running", {31'd0, running}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
